mem_cycle_ctl: RTL

Memory cycle controller between the PDP-8/I processor timing logic and the 32k×12 memory. It accepts one memory request at a time and forms the 15-bit address from field and address. It drives the memory start/done handshake and captures read data on the sense strobe. It also supplies the write-back word for the memory's restore phase: the original word, a deposited word, or the incremented word.

---
 rtl/mem_cycle_ctl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_cycle_ctl.sv
// Memory cycle controller for the PDP-8/I 32k x 12 core: request accept, start/done handshake, read capture, write-back word.
// Optional watchdog abort is built when MEMCTL_TIMEOUT_EN is defined; otherwise err is tied low and cycles wait indefinitely.
module mem_cycle_ctl #(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [1:0]  op,
  input  logic [2:0]  field,
  input  logic [11:0] addr,
  input  logic [11:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [11:0] rdata,
  output logic        inc_zero,
  output logic        err,
  output logic        mem_start,
  input  logic        mem_done_n,
  input  logic        strobe_n,
  output logic [14:0] mem_addr,
  output logic [11:0] mem_data,
  input  logic [11:0] mem_rdata
);

  localparam int unsigned DW = 12;
  localparam int unsigned AW = 15;
  localparam int unsigned HW = 5;
  localparam int unsigned WW = 6;

  localparam logic [1:0] OP_DEP = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_ARM   = 3'd3,
    S_WAIT  = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [1:0]      op_q, op_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_data_q, mem_data_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            inc_zero_q, inc_zero_d;
  logic            done_q, done_d;
  logic            mem_start_q, mem_start_d;
  logic            busy_q, busy_d;
  logic            in_cycle_c;
  logic            abort_c;

  assign in_cycle_c = (state_q == S_START) || (state_q == S_ARM) || (state_q == S_WAIT);

`ifdef MEMCTL_TIMEOUT_EN
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;

  assign abort_c = in_cycle_c && (wdog_q == WW'(TIMEOUT - 1));

  // Watchdog runs from accept until the cycle ends; err stays up until the next accept.
  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q;
    if ((state_q == S_IDLE) && req) begin
      wdog_d = '0;
      err_d  = 1'b0;
    end else if (in_cycle_c) begin
      wdog_d = wdog_q + WW'(1);
      if (abort_c) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^WW'(TIMEOUT);
  assign abort_c        = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_HOLD;
    else          state_q <= state_d;
  end

  // Next state; HOLD lets a memory cycle orphaned by reset or abort run out.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD:  if (hold_cnt_q == '1) state_d = S_IDLE;
      S_IDLE:  if (req)              state_d = S_START;
      S_START: if (mem_done_n)       state_d = S_ARM;
      S_ARM:   if (!strobe_n)        state_d = S_WAIT;
      S_WAIT:  if (!mem_done_n)      state_d = S_IDLE;
      default:                       state_d = S_HOLD;
    endcase
    if (abort_c) state_d = S_HOLD;
  end

  // Datapath and output register next values.
  always_comb begin
    hold_cnt_d  = (state_q == S_HOLD) ? hold_cnt_q + HW'(1) : '0;
    op_d        = op_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    rdata_d     = rdata_q;
    inc_zero_d  = inc_zero_q;
    done_d      = 1'b0;
    mem_start_d = mem_start_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d        = op;
          mem_addr_d  = {field, addr};
          inc_zero_d  = 1'b0;
          mem_start_d = 1'b1;
          if (op == OP_DEP) mem_data_d = wdata;
        end
      end
      S_ARM: begin
        if (!strobe_n) begin
          rdata_d = mem_rdata;
          case (op_q)
            OP_DEP: mem_data_d = mem_data_q;
            OP_INC: begin
              mem_data_d = mem_rdata + DW'(1);
              inc_zero_d = (mem_rdata == '1);
            end
            default: mem_data_d = mem_rdata;
          endcase
        end
      end
      S_WAIT: begin
        if (!mem_done_n) begin
          mem_start_d = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
    // An aborted cycle reports completion but leaves the captured results untouched.
    if (abort_c) begin
      rdata_d     = rdata_q;
      mem_data_d  = mem_data_q;
      inc_zero_d  = inc_zero_q;
      mem_start_d = 1'b0;
      done_d      = 1'b1;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt_q  <= '0;
      op_q        <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      rdata_q     <= '0;
      inc_zero_q  <= 1'b0;
      done_q      <= 1'b0;
      mem_start_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      op_q        <= op_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      rdata_q     <= rdata_d;
      inc_zero_q  <= inc_zero_d;
      done_q      <= done_d;
      mem_start_q <= mem_start_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign inc_zero  = inc_zero_q;
  assign mem_start = mem_start_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;

endmodule
